calc_result_deser: RTL and testbench
====================================

// Module: calc_result_deser
// PURPOSE
//  Downstream receiver for the calculator's serial result port. Samples DataOut
//  nibbles on ClkTx rising edges while DoutValid is high, reassembles them
//  MSB-chunk-first into WORD-bit results and buffers them in a small FWFT FIFO
//  for the host/scoreboard side. Flags dropped words and truncated frames.
// PARAMETERS
//  SBITI  4   width of one serial chunk (DataOut); must divide WORD
//  WORD   32  assembled result width; CHUNKS = WORD/SBITI (8 by default)
//  DEPTH  4   FIFO depth in words, power of two, >= 2
// PORTS
//  Clk        in   1                 system clock; all logic on posedge Clk
//  Reset      in   1                 asynchronous, active-low reset
//  ClkTx      in   1                 serial bit clock, generated from Clk (same domain, no sync)
//  DoutValid  in   1                 frame-active qualifier from calculator
//  DataOut    in   SBITI             serial chunk, valid at ClkTx rising edge
//  RdEn       in   1                 pop head word; ignored when RdValid=0
//  ClrErr     in   1                 synchronous clear of sticky flags
//  RdValid    out  1                 FIFO not empty; RdData holds head word
//  RdData     out  WORD              head of FIFO (FWFT)
//  Count      out  $clog2(DEPTH)+1   words stored
//  Overflow   out  1                 sticky: completed word dropped, FIFO full
//  FrameErr   out  1                 sticky: DoutValid fell mid-word
// BEHAVIOUR
//  Reset (Reset=0, async): all outputs 0, FSM=IDLE, chunk cnt=0, shift reg=0,
//    FIFO pointers=0, ClkTx_q=0.
//  Edge detect: ClkTx_q <= ClkTx each cycle; tick = ClkTx & ~ClkTx_q & DoutValid.
//  FSM IDLE: DoutValid=0 or no tick; on tick -> shift chunk in, cnt=1, go RECV.
//    (If CHUNKS=1 the first tick completes the word directly.)
//  FSM RECV: each tick shifts {sr[WORD-SBITI-1:0], DataOut}, cnt++.
//    tick with cnt==CHUNKS-1: word = {sr, DataOut} pushed on that same edge,
//    cnt=0, stay RECV if DoutValid else IDLE. RdValid visible next cycle (1 clk).
//    DoutValid=0 with cnt!=0: discard partial, FrameErr<=1, cnt=0, -> IDLE.
//    DoutValid=0 with cnt==0: -> IDLE, no error.
//  Back-to-back words in one frame allowed; cnt wraps CHUNKS-1 -> 0.
//  FIFO: push on word complete; pop on RdEn&RdValid. Full & push & no pop:
//    word dropped, Overflow<=1, contents unchanged. Full & push & pop same
//    cycle: both happen, Count unchanged. Empty & RdEn: no effect.
//    Pointers wrap modulo DEPTH; Count in 0..DEPTH.
//  ClrErr=1 clears Overflow/FrameErr; a same-cycle set event wins (flag stays 1).
//  Reset mid-frame: partial word and FIFO contents lost; no flags set.
// STRUCTURE
//  calc_pkg: SBITI/WORD defaults, CHUNKS localparam, typedef enum {IDLE,RECV}.
//  Sub-module calc_rx_fifo (sync FWFT FIFO, WORD x DEPTH, push/pop/full/empty/
//  count); deser FSM, shift register and sticky flags in the top.
// TESTING
//  1 one frame, chunks 1,2,...,8 -> RdValid 1 clk after 8th tick, RdData=32'h12345678.
//  2 DoutValid drops after 5 chunks -> FrameErr=1, Count=0; next full frame
//    0xDEADBEEF received intact.
//  3 five words, DEPTH=4, RdEn=0 -> Count=4, Overflow=1, FIFO holds words 1-4.
//  4 FIFO full, 8th tick of new word with RdEn=1 -> pop word1, push new, Count=4,
//    Overflow unchanged.
//  5 one frame of 2 back-to-back words 0xA5A5A5A5,0x0F0F0F0F -> both in order, no FrameErr.
//  6 Reset pulsed after 3 chunks, then full frame 0xCAFEF00D -> only that word, flags 0.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | calc_pkg: shared defaults and FSM state type for calc_result_deser       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package calc_pkg;

  localparam int DEF_SBITI  = 4;
  localparam int DEF_WORD   = 32;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_CHUNKS = DEF_WORD / DEF_SBITI;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } deser_state_t;

endpackage
`default_nettype wire

// File: rtl/calc_result_deser_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | calc_result_deser_if: serial result port plus FWFT read port             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface calc_result_deser_if #(
  parameter int SBITI = 4,
  parameter int WORD  = 32
);

  logic             ClkTx;
  logic             DoutValid;
  logic [SBITI-1:0] DataOut;
  logic             RdEn;
  logic             RdValid;
  logic [WORD-1:0]  RdData;

  modport master (
    output ClkTx, DoutValid, DataOut, RdEn,
    input  RdValid, RdData
  );

  modport slave (
    input  ClkTx, DoutValid, DataOut, RdEn,
    output RdValid, RdData
  );

endinterface
`default_nettype wire

// File: rtl/calc_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | calc_rx_fifo: synchronous first-word-fall-through FIFO, WORD x DEPTH     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module calc_rx_fifo #(
  parameter int WORD  = 32,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     push,
  input  wire logic [WORD-1:0]          push_data,
  input  wire logic                     pop,
  output logic      [WORD-1:0]          head_data,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/calc_result_deser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | calc_result_deser: reassembles serial result chunks into words + FIFO    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module calc_result_deser
  import calc_pkg::*;
#(
  parameter int SBITI = DEF_SBITI,
  parameter int WORD  = DEF_WORD,
  parameter int DEPTH = DEF_DEPTH
) (
  input  wire logic                   Clk,
  input  wire logic                   Reset,
  input  wire logic                   ClrErr,
  calc_result_deser_if.slave          bus,
  output logic [$clog2(DEPTH):0]      Count,
  output logic                        Overflow,
  output logic                        FrameErr
);

  localparam int CHUNKS = WORD / SBITI;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

  deser_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WORD-1:0]  sr, sr_nxt;
  logic [WORD-1:0]  shifted;
  logic             clktx_q;
  logic             tick;
  logic             push;
  logic             frame_err_set;
  logic             overflow_set;
  logic             pop_req;
  logic             fifo_full;
  logic             fifo_empty;

  assign tick    = bus.ClkTx & ~clktx_q & bus.DoutValid;
  assign shifted = (sr << SBITI) | WORD'(bus.DataOut);
  assign pop_req = bus.RdEn & ~fifo_empty;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sr      <= '0;
      clktx_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sr      <= sr_nxt;
      clktx_q <= bus.ClkTx;
    end
  end

  // cnt is always zero in IDLE, so a tick is handled identically in both states.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    sr_nxt        = sr;
    push          = 1'b0;
    frame_err_set = 1'b0;
    if (tick) begin
      sr_nxt    = shifted;
      state_nxt = RECV;
      if (cnt == LAST_CHUNK) begin
        push    = 1'b1;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else if (state == RECV && !bus.DoutValid) begin
      frame_err_set = (cnt != '0);
      cnt_nxt       = '0;
      state_nxt     = IDLE;
    end
  end

  assign overflow_set = push & fifo_full & ~pop_req;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Overflow <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      Overflow <= overflow_set  | (Overflow & ~ClrErr);
      FrameErr <= frame_err_set | (FrameErr & ~ClrErr);
    end
  end

  calc_rx_fifo #(
    .WORD  (WORD),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (Clk),
    .rst_n     (Reset),
    .push      (push),
    .push_data (shifted),
    .pop       (pop_req),
    .head_data (bus.RdData),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (Count)
  );

  assign bus.RdValid = ~fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_calc_result_deser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_calc_result_deser: scoreboard bench for the serial result receiver    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_calc_result_deser;

  localparam int SBITI  = 4;
  localparam int WORD   = 32;
  localparam int DEPTH  = 4;
  localparam int CHUNKS = WORD / SBITI;

  logic                  Clk;
  logic                  Reset;
  logic                  ClrErr;
  logic [$clog2(DEPTH):0] Count;
  logic                  Overflow;
  logic                  FrameErr;

  calc_result_deser_if #(.SBITI(SBITI), .WORD(WORD)) bus ();

  calc_result_deser #(.SBITI(SBITI), .WORD(WORD), .DEPTH(DEPTH)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ClrErr   (ClrErr),
    .bus      (bus.slave),
    .Count    (Count),
    .Overflow (Overflow),
    .FrameErr (FrameErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  int model_count  = 0;
  logic [WORD-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send_chunk(input logic [SBITI-1:0] d, input bit pop_now);
    @(negedge Clk);
    bus.DataOut = d;
    bus.ClkTx   = 1'b1;
    if (pop_now) begin
      bus.RdEn = 1'b1;
      check("head_at_pop", bus.RdData, exp_q.pop_front());
      model_count--;
    end
    @(negedge Clk);
    bus.ClkTx = 1'b0;
    bus.RdEn  = 1'b0;
  endtask

  // Word is sent MSB chunk first; the model only queues what fits in the FIFO.
  task automatic send_word(input logic [WORD-1:0] w, input bit pop_last, input bit check_latency);
    bus.DoutValid = 1'b1;
    for (int i = CHUNKS - 1; i >= 0; i--) begin
      if (check_latency && i == 0) begin
        @(negedge Clk);
        check("rdvalid_before_last", bus.RdValid, 1'b0);
      end
      send_chunk(w[i*SBITI +: SBITI], pop_last && i == 0);
    end
    if (model_count < DEPTH) begin
      exp_q.push_back(w);
      model_count++;
    end
  endtask

  task automatic end_frame();
    @(negedge Clk);
    bus.DoutValid = 1'b0;
    @(negedge Clk);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    @(negedge Clk);
    while (exp_q.size() > 0 && guard < 40) begin
      guard++;
      if (bus.RdValid) begin
        check(tag, bus.RdData, exp_q.pop_front());
        model_count--;
        bus.RdEn = 1'b1;
        @(negedge Clk);
        bus.RdEn = 1'b0;
      end else begin
        @(negedge Clk);
      end
    end
    check({tag, "_left"}, exp_q.size(), 0);
    exp_q.delete();
    model_count = 0;
    check({tag, "_count"}, Count, 0);
    check({tag, "_rdvalid"}, bus.RdValid, 1'b0);
  endtask

  task automatic clear_errs();
    @(negedge Clk);
    ClrErr = 1'b1;
    @(negedge Clk);
    ClrErr = 1'b0;
  endtask

  initial begin
    Reset         = 1'b0;
    ClrErr        = 1'b0;
    bus.ClkTx     = 1'b0;
    bus.DoutValid = 1'b0;
    bus.DataOut   = '0;
    bus.RdEn      = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_rdvalid", bus.RdValid, 1'b0);
    check("rst_rddata", bus.RdData, 0);
    check("rst_count", Count, 0);
    check("rst_overflow", Overflow, 1'b0);
    check("rst_frameerr", FrameErr, 1'b0);
    Reset = 1'b1;

    // Single word, one clock latency to RdValid
    send_word(32'h12345678, 1'b0, 1'b1);
    check("t1_rdvalid", bus.RdValid, 1'b1);
    check("t1_count", Count, 1);
    end_frame();
    drain("t1_data");

    // Empty pop has no effect
    @(negedge Clk);
    bus.RdEn = 1'b1;
    @(negedge Clk);
    bus.RdEn = 1'b0;
    check("empty_pop_count", Count, 0);

    // Truncated frame, then an intact one
    bus.DoutValid = 1'b1;
    for (int i = 0; i < 5; i++) send_chunk(SBITI'(i + 3), 1'b0);
    end_frame();
    check("t2_frameerr", FrameErr, 1'b1);
    check("t2_count", Count, 0);
    clear_errs();
    check("t2_frameerr_clr", FrameErr, 1'b0);
    send_word(32'hDEADBEEF, 1'b0, 1'b0);
    end_frame();
    check("t2_no_frameerr", FrameErr, 1'b0);
    drain("t2_data");

    // Five words into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send_word(32'h1111_0000 + WORD'(i), 1'b0, 1'b0);
    end_frame();
    check("t3_count", Count, DEPTH);
    check("t3_overflow", Overflow, 1'b1);
    check("t3_head", bus.RdData, exp_q[0]);

    // Full FIFO: push and pop on the same edge
    send_word(32'hBEEF_0006, 1'b1, 1'b0);
    end_frame();
    check("t4_count", Count, DEPTH);
    check("t4_overflow", Overflow, 1'b1);
    drain("t4_data");
    clear_errs();
    check("t4_overflow_clr", Overflow, 1'b0);

    // Two back-to-back words in one frame
    send_word(32'hA5A5A5A5, 1'b0, 1'b0);
    send_word(32'h0F0F0F0F, 1'b0, 1'b0);
    end_frame();
    check("t5_count", Count, 2);
    check("t5_frameerr", FrameErr, 1'b0);
    drain("t5_data");

    // Reset mid-frame discards the partial word without flags
    bus.DoutValid = 1'b1;
    for (int i = 0; i < 3; i++) send_chunk(SBITI'(4'hF - i), 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    bus.DoutValid = 1'b0;
    @(negedge Clk);
    send_word(32'hCAFEF00D, 1'b0, 1'b0);
    end_frame();
    check("t6_count", Count, 1);
    check("t6_frameerr", FrameErr, 1'b0);
    check("t6_overflow", Overflow, 1'b0);
    drain("t6_data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
